// File: rtl/mac_pkg.sv
// Shared types and widths for the MAC accumulate stage.
package mac_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } acc_state_t;

endpackage

// File: rtl/mac_acc_ctrl_if.sv
// Term stream, run control and result signals between the multiplier side and the accumulate controller.
interface mac_acc_ctrl_if;
  import mac_pkg::*;

  logic              start;
  logic [CNT_W-1:0]  len;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [DATA_W-1:0] acc_out;
  logic              ovf;
  logic              busy;
  logic              done;

  modport master (
    output start, len, in_valid, in_data,
    input  in_ready, acc_out, ovf, busy, done
  );

  modport slave (
    input  start, len, in_valid, in_data,
    output in_ready, acc_out, ovf, busy, done
  );

endinterface

// File: rtl/RCA_16b.sv
// 16-bit ripple-carry adder, sum wraps modulo 2^16 with no carry-out.
module RCA_16b (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] sum_o
);

  logic carry;

  always_comb begin
    carry = 1'b0;
    sum_o = '0;
    for (int i = 0; i < 16; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
  end

endmodule

// File: rtl/mac_acc_ctrl.sv
// Accumulate-stage sequencer: sums len terms from a valid/ready stream through one shared adder,
// reports the wrapped sum, a sticky wrap flag and a one-cycle done pulse.
module mac_acc_ctrl
  import mac_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  mac_acc_ctrl_if.slave  bus
);

  acc_state_t        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] add_b, sum;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic              ovf_q, ovf_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start_c, xfer_c, last_c;

  assign start_c = (state_q == IDLE) && bus.start;
  assign xfer_c  = in_ready_q && bus.in_valid;
  assign last_c  = (cnt_q == CNT_W'(len_q - CNT_W'(1)));

  // B operand only sees the stream while accumulating.
  assign add_b = (state_q == ACC) ? bus.in_data : '0;

  RCA_16b u_rca (
    .a_i   (acc_q),
    .b_i   (add_b),
    .sum_o (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      ovf_q      <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_c) state_d = (bus.len == '0) ? DONE : ACC;
      ACC:  if (xfer_c && last_c) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Flags are decoded from the next state so they register in step with it.
  always_comb begin
    in_ready_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    unique case (state_d)
      ACC: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
      DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Wrap shows up as the registered sum dropping below the old accumulator.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    len_d = len_q;
    ovf_d = ovf_q;
    if (start_c) begin
      len_d = bus.len;
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (xfer_c) begin
      acc_d = sum;
      cnt_d = CNT_W'(cnt_q + CNT_W'(1));
      ovf_d = ovf_q | (sum < acc_q);
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.acc_out  = acc_q;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_mac_acc_ctrl.sv
// Bench for mac_acc_ctrl: directed cases plus random runs, checked every cycle against a run-level model.
module tb_mac_acc_ctrl;

  logic clk;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  mac_acc_ctrl_if bus ();

  mac_acc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Run-level model: an unbounded running total; the wrapped view and the wrap flag derive from it.
  bit          m_run  = 1'b0;
  bit          m_done = 1'b0;
  int          m_left = 0;
  longint      m_total = 0;

  always @(posedge clk) begin
    bit nd;
    nd = 1'b0;
    if (rst) begin
      m_run   = 1'b0;
      m_left  = 0;
      m_total = 0;
    end else if (m_done) begin
    end else if (!m_run) begin
      if (bus.start) begin
        m_total = 0;
        if (bus.len == 8'd0) nd = 1'b1;
        else begin
          m_run  = 1'b1;
          m_left = int'(bus.len);
        end
      end
    end else if (bus.in_valid) begin
      m_total = m_total + longint'(bus.in_data);
      m_left  = m_left - 1;
      if (m_left == 0) begin
        m_run = 1'b0;
        nd    = 1'b1;
      end
    end
    m_done = nd;
    #1;
    chk("cyc_in_ready", 32'(bus.in_ready), 32'(m_run));
    chk("cyc_busy",     32'(bus.busy),     32'(m_run | m_done));
    chk("cyc_done",     32'(bus.done),     32'(m_done));
    chk("cyc_acc_out",  32'(bus.acc_out),  32'(m_total[15:0]));
    chk("cyc_ovf",      32'(bus.ovf),      32'(m_total > 64'd65535));
  end

  task automatic do_start(input logic [7:0] l);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = l;
    @(negedge clk);
    bus.start = 1'b0;
    bus.len   = 8'($urandom);
  endtask

  task automatic send(input logic [15:0] d, input int bub, input bit poke);
    bit ok;
    ok = 1'b0;
    for (int b = 0; b < bub; b++) begin
      bus.in_valid = 1'b0;
      bus.start    = poke;
      bus.len      = 8'($urandom);
      bus.in_data  = 16'($urandom);
      @(negedge clk);
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int k = 0; k < 20; k++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("term_accepted", 32'(ok), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    int rdy_cnt;
    int l;
    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.len      = 8'd5;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_done",     32'(bus.done),     32'd0);
    chk("rst_acc_out",  32'(bus.acc_out),  32'h0);
    chk("rst_ovf",      32'(bus.ovf),      32'd0);
    bus.start = 1'b0;
    rst       = 1'b0;

    // len=4, back-to-back terms 1..4
    do_start(8'd4);
    rdy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = (i < 4);
      bus.in_data  = 16'(i + 1);
      if (bus.in_ready) rdy_cnt++;
      if (i == 4) begin
        chk("run4_done", 32'(bus.done),    32'd1);
        chk("run4_acc",  32'(bus.acc_out), 32'h000A);
        chk("run4_ovf",  32'(bus.ovf),     32'd0);
        chk("model_run4_acc", 32'(m_total[15:0]), 32'h000A);
      end
      @(negedge clk);
    end
    chk("run4_ready_cycles", 32'(rdy_cnt), 32'd4);

    // wrap then flag clear on the next start
    do_start(8'd2);
    send(16'hFFFF, 0, 1'b0);
    send(16'h0002, 0, 1'b0);
    wait_done();
    chk("wrap_acc", 32'(bus.acc_out), 32'h0001);
    chk("wrap_ovf", 32'(bus.ovf),     32'd1);
    chk("model_wrap_acc", 32'(m_total[15:0]), 32'h0001);
    do_start(8'd1);
    send(16'h0005, 0, 1'b0);
    wait_done();
    chk("clr_acc", 32'(bus.acc_out), 32'h0005);
    chk("clr_ovf", 32'(bus.ovf),     32'd0);

    // bubbles with ignored start pulses
    do_start(8'd3);
    send(16'h0100, 0, 1'b0);
    send(16'h0200, 2, 1'b1);
    send(16'h0300, 2, 1'b1);
    wait_done();
    chk("bub_acc", 32'(bus.acc_out), 32'h0600);
    chk("model_bub_acc", 32'(m_total[15:0]), 32'h0600);

    // len=0 finishes immediately
    do_start(8'd0);
    chk("len0_done",     32'(bus.done),     32'd1);
    chk("len0_in_ready", 32'(bus.in_ready), 32'd0);
    chk("len0_acc",      32'(bus.acc_out),  32'h0);

    // reset in the middle of a run
    do_start(8'd4);
    send(16'h0011, 0, 1'b0);
    send(16'h0022, 0, 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(bus.busy),    32'd0);
    chk("mid_rst_acc",  32'(bus.acc_out), 32'h0);
    chk("mid_rst_done", 32'(bus.done),    32'd0);
    do_start(8'd1);
    send(16'h0007, 0, 1'b0);
    wait_done();
    chk("post_rst_acc", 32'(bus.acc_out), 32'h0007);

    // random runs, first one at full length to force wraps
    for (int r = 0; r < 40; r++) begin
      l = (r == 0) ? 255 : int'($urandom_range(0, 12));
      do_start(8'(l));
      if (l >= 2 && $urandom_range(0, 7) == 0) begin
        for (int t = 0; t < l / 2; t++)
          send(16'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else begin
        for (int t = 0; t < l; t++)
          send((r == 0) ? 16'(16'hF000 | 16'($urandom)) : 16'($urandom),
               (r == 0) ? 0 : int'($urandom_range(0, 2)), 1'($urandom));
        wait_done();
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
